loom_axil_demux_ot: RTL and testbench
=====================================

// Module: loom_axil_demux_ot
// PURPOSE
//  AXI-Lite 1:N demux with multiple outstanding transactions per direction, generic data width
//  and a built-in DECERR responder for unmapped addresses. Sits between the host AXI-Lite master
//  and the Loom peripheral slaves. Per-slave addresses are base-relative: addr - BASE_ADDR[i].
// PARAMETERS
//  ADDR_WIDTH  20   address width
//  DATA_WIDTH  32   data width (multiple of 8); STRB_W = DATA_WIDTH/8
//  N_MASTERS   3    number of downstream slaves (>=1)
//  MAX_OUTST   4    max outstanding transactions per direction (>=1)
//  BASE_ADDR   '0   [N_MASTERS][ADDR_WIDTH] match value; match when (addr & ADDR_MASK[i]) == BASE_ADDR[i]
//  ADDR_MASK   '0   [N_MASTERS][ADDR_WIDTH] match mask; lowest matching index wins
// PORTS
//  Clock and reset: one clock; reset is synchronous and active-low.
//  clk_i           in   1                clock
//  rst_ni          in   1                synchronous active-low reset
//  s_axil_{ar,aw}addr_i   in   ADDR_WIDTH   upstream addresses; s_axil_{ar,aw,w}valid_i/ready_o handshakes
//  s_axil_wdata_i/wstrb_i in   DATA_WIDTH/STRB_W   write data and strobe
//  s_axil_rdata_o/rresp_o/rvalid_o/rready_i   read response; s_axil_bresp_o/bvalid_o/bready_i   write response
//  m_axil_*        flat N_MASTERS*width vectors, same channel set as s_axil_*, directions reversed
// BEHAVIOUR
//  - Target index t in 0..N_MASTERS-1; t==N_MASTERS (no match) selects the internal error slave (ERR).
//  - Per direction: cnt_q (0..MAX_OUTST) and sel_q (last accepted target).
//    cnt_q increments on address handshake and decrements on response handshake; +1 -1 in the same cycle leaves it unchanged.
//  - AR/AW accept gate: cnt_q < MAX_OUTST && (cnt_q == 0 || t == sel_q).
//    A target switch stalls until the direction drains, so responses stay in order.
//  - m_*valid to target t only when the gate is open. s_*ready = the target's ready, or 1 for ERR.
//    No combinational s_valid -> s_ready dependency beyond a single mux.
//  - W routing: wowed_q counts accepted AWs whose W has not been forwarded.
//    W is forwarded to sel_q (or the ERR sink, wready=1) only when wowed_q != 0,
//    or in the same cycle as an AW handshake (then routed to that AW's t).
//    W never precedes its AW.
//  - R/B mux: selected by sel_q while cnt_q != 0. m_rready/m_bready go to sel_q only; others are 0.
//  - ERR slave:
//    reads: rvalid=1 for each pending ERR read; rdata='0, rresp=2'b11.
//    writes: bvalid once its W has been sunk; bresp=2'b11. Tracked by errw_q (W-sunk minus B-given).
//  - Responses pass through 0-cycle combinational, address/data 0-cycle; no added pipeline stage.
//  - Reset (rst_ni=0 at posedge): cnt_q=0, sel_q=0, wowed_q=0, errw_q=0.
//    All s_*ready_o, s_rvalid_o, s_bvalid_o, m_*valid_o, m_rready_o, m_bready_o = 0.
//    rresp/bresp=0, rdata=0. A mid-transaction reset drops all outstanding state; slaves are reset together.
//  - Boundaries:
//    cnt_q==MAX_OUTST: ready=0 until a response handshake.
//    Response handshake in the same cycle as a new same-target address: accepted.
//    Mask of all-zero with BASE=0 matches everything.
// CONFIGURATION
//  LOOM_AXIL_DEMUX_ERRLOG_EN defined: adds err_valid_o(1), err_is_write_o(1), err_addr_o(ADDR_WIDTH), err_clear_i(1).
//    Captures the first DECERR address at its AR/AW handshake (read wins on tie).
//    err_valid_o is sticky until err_clear_i=1 (clear has priority over a same-cycle capture). Reset: all 0.
//  Not defined: ports absent, no capture logic; DECERR responses are unchanged.
// TESTING
//  1 Read 4x back-to-back to slave 1 with rready=1 and slave latency 3
//      -> 4 ARs accepted without stall, 4 R beats in order, cnt_q back to 0.
//  2 Read to slave 0 then to slave 2 while slave 0 is pending
//      -> AR to slave 2 held (arready=0) until slave 0's R handshake, then forwarded with addr-BASE_ADDR[2].
//  3 Read at an unmapped address
//      -> arready=1; next cycle rvalid=1, rdata=0, rresp=2'b11; no m_arvalid asserted.
//  4 Write with AW and W in the same cycle, then W-before-AW
//      -> the first is forwarded together; in the second wready=0 until AW accepted, bresp passed from slave.
//  5 MAX_OUTST+1 writes to one slave with bready=0 -> 5th AW stalled; releasing bready drains 4 B responses.
//  6 Reset asserted with 2 reads outstanding -> all valids/readies 0 next cycle; a fresh read completes normally.

Source files
------------

// File: rtl/loom_axil_demux_ot.sv
// loom_axil_demux_ot: AXI-Lite 1:N demux, in-order outstanding txns,
// built-in DECERR slave. Optional error log: LOOM_AXIL_DEMUX_ERRLOG_EN.
// Ports: clk_i, rst_ni (sync, active-low); s_axil_* upstream slave port;
// m_axil_* flat N_MASTERS-wide downstream master ports;
// err_valid_o/err_is_write_o/err_addr_o/err_clear_i when log enabled.
module loom_axil_demux_ot #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_MASTERS  = 3,
  parameter int unsigned MAX_OUTST  = 4,
  parameter logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] ADDR_MASK = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr_i,
  input  logic                      s_axil_arvalid_i,
  output logic                      s_axil_arready_o,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr_i,
  input  logic                      s_axil_awvalid_i,
  output logic                      s_axil_awready_o,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb_i,
  input  logic                      s_axil_wvalid_i,
  output logic                      s_axil_wready_o,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata_o,
  output logic [1:0]                s_axil_rresp_o,
  output logic                      s_axil_rvalid_o,
  input  logic                      s_axil_rready_i,
  output logic [1:0]                s_axil_bresp_o,
  output logic                      s_axil_bvalid_o,
  input  logic                      s_axil_bready_i,
  output logic [N_MASTERS*ADDR_WIDTH-1:0] m_axil_araddr_o,
  output logic [N_MASTERS-1:0]      m_axil_arvalid_o,
  input  logic [N_MASTERS-1:0]      m_axil_arready_i,
  output logic [N_MASTERS*ADDR_WIDTH-1:0] m_axil_awaddr_o,
  output logic [N_MASTERS-1:0]      m_axil_awvalid_o,
  input  logic [N_MASTERS-1:0]      m_axil_awready_i,
  output logic [N_MASTERS*DATA_WIDTH-1:0] m_axil_wdata_o,
  output logic [N_MASTERS*DATA_WIDTH/8-1:0] m_axil_wstrb_o,
  output logic [N_MASTERS-1:0]      m_axil_wvalid_o,
  input  logic [N_MASTERS-1:0]      m_axil_wready_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_axil_rdata_i,
  input  logic [N_MASTERS*2-1:0]    m_axil_rresp_i,
  input  logic [N_MASTERS-1:0]      m_axil_rvalid_i,
  output logic [N_MASTERS-1:0]      m_axil_rready_o,
  input  logic [N_MASTERS*2-1:0]    m_axil_bresp_i,
  input  logic [N_MASTERS-1:0]      m_axil_bvalid_i,
  output logic [N_MASTERS-1:0]      m_axil_bready_o
`ifdef LOOM_AXIL_DEMUX_ERRLOG_EN
  ,
  output logic                      err_valid_o,
  output logic                      err_is_write_o,
  output logic [ADDR_WIDTH-1:0]     err_addr_o,
  input  logic                      err_clear_i
`endif
);

  localparam int unsigned TW = $clog2(N_MASTERS + 1);
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam logic [TW-1:0] ERR  = TW'(N_MASTERS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);

  // Lowest matching index wins: scan downwards, last hit sticks.
  function automatic logic [TW-1:0] decode(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [TW-1:0] t;
    t = ERR;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if ((a & ADDR_MASK[i]) == BASE_ADDR[i]) t = TW'(i);
    end
    return t;
  endfunction

  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [TW-1:0] rd_sel_q, rd_sel_d;
  logic [TW-1:0] wr_sel_q, wr_sel_d;
  logic [CW-1:0] wowed_q, wowed_d;
  logic [CW-1:0] errw_q, errw_d;

  logic [TW-1:0] ar_t, aw_t, w_t;
  logic ar_gate, aw_gate, w_en;
  logic rd_busy, wr_busy;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;

  assign m_axil_wdata_o = {N_MASTERS{s_axil_wdata_i}};
  assign m_axil_wstrb_o = {N_MASTERS{s_axil_wstrb_i}};

  always_comb begin
    ar_t = decode(s_axil_araddr_i);
    aw_t = decode(s_axil_awaddr_i);
    // A new target is only taken once the direction has drained,
    // which keeps responses in issue order without reorder buffers.
    ar_gate = rst_ni && (rd_cnt_q < MAXC) &&
              (rd_cnt_q == '0 || ar_t == rd_sel_q);
    aw_gate = rst_ni && (wr_cnt_q < MAXC) &&
              (wr_cnt_q == '0 || aw_t == wr_sel_q);
    rd_busy = rst_ni && (rd_cnt_q != '0);
    wr_busy = rst_ni && (wr_cnt_q != '0);

    m_axil_arvalid_o = '0;
    m_axil_awvalid_o = '0;
    m_axil_wvalid_o  = '0;
    m_axil_rready_o  = '0;
    m_axil_bready_o  = '0;
    m_axil_araddr_o  = '0;
    m_axil_awaddr_o  = '0;
    s_axil_arready_o = ar_gate && (ar_t == ERR);
    s_axil_awready_o = aw_gate && (aw_t == ERR);
    s_axil_rvalid_o  = 1'b0;
    s_axil_rdata_o   = '0;
    s_axil_rresp_o   = 2'b00;
    s_axil_bvalid_o  = 1'b0;
    s_axil_bresp_o   = 2'b00;

    if (rd_busy && rd_sel_q == ERR) begin
      s_axil_rvalid_o = 1'b1;
      s_axil_rresp_o  = 2'b11;
    end
    if (wr_busy && wr_sel_q == ERR) begin
      s_axil_bvalid_o = (errw_q != '0);
      s_axil_bresp_o  = 2'b11;
    end

    for (int i = 0; i < int'(N_MASTERS); i++) begin
      m_axil_araddr_o[i*ADDR_WIDTH +: ADDR_WIDTH] =
        s_axil_araddr_i - BASE_ADDR[i];
      m_axil_awaddr_o[i*ADDR_WIDTH +: ADDR_WIDTH] =
        s_axil_awaddr_i - BASE_ADDR[i];
      if (ar_t == TW'(i)) begin
        m_axil_arvalid_o[i] = ar_gate && s_axil_arvalid_i;
        s_axil_arready_o    = ar_gate && m_axil_arready_i[i];
      end
      if (aw_t == TW'(i)) begin
        m_axil_awvalid_o[i] = aw_gate && s_axil_awvalid_i;
        s_axil_awready_o    = aw_gate && m_axil_awready_i[i];
      end
      if (rd_busy && rd_sel_q == TW'(i)) begin
        s_axil_rvalid_o    = m_axil_rvalid_i[i];
        s_axil_rdata_o     = m_axil_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_axil_rresp_o     = m_axil_rresp_i[i*2 +: 2];
        m_axil_rready_o[i] = s_axil_rready_i;
      end
      if (wr_busy && wr_sel_q == TW'(i)) begin
        s_axil_bvalid_o    = m_axil_bvalid_i[i];
        s_axil_bresp_o     = m_axil_bresp_i[i*2 +: 2];
        m_axil_bready_o[i] = s_axil_bready_i;
      end
    end

    aw_hs = s_axil_awvalid_i && s_axil_awready_o;
    // W follows its AW: either an older AW is still owed data,
    // or it rides along with the AW accepted this cycle.
    w_en = rst_ni && (wowed_q != '0 || aw_hs);
    w_t  = (wowed_q != '0) ? wr_sel_q : aw_t;
    s_axil_wready_o = w_en && (w_t == ERR);
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (w_t == TW'(i)) begin
        m_axil_wvalid_o[i] = w_en && s_axil_wvalid_i;
        s_axil_wready_o    = w_en && m_axil_wready_i[i];
      end
    end

    ar_hs = s_axil_arvalid_i && s_axil_arready_o;
    w_hs  = s_axil_wvalid_i && s_axil_wready_o;
    r_hs  = s_axil_rvalid_o && s_axil_rready_i;
    b_hs  = s_axil_bvalid_o && s_axil_bready_i;

    rd_cnt_d = rd_cnt_q + CW'(ar_hs) - CW'(r_hs);
    wr_cnt_d = wr_cnt_q + CW'(aw_hs) - CW'(b_hs);
    rd_sel_d = ar_hs ? ar_t : rd_sel_q;
    wr_sel_d = aw_hs ? aw_t : wr_sel_q;
    wowed_d  = wowed_q + CW'(aw_hs) - CW'(w_hs);
    errw_d   = errw_q + CW'(w_hs && w_t == ERR)
                      - CW'(b_hs && wr_sel_q == ERR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_sel_q <= '0;
      wr_sel_q <= '0;
      wowed_q  <= '0;
      errw_q   <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_sel_q <= rd_sel_d;
      wr_sel_q <= wr_sel_d;
      wowed_q  <= wowed_d;
      errw_q   <= errw_d;
    end
  end

`ifdef LOOM_AXIL_DEMUX_ERRLOG_EN
  logic                  err_valid_q, err_valid_d;
  logic                  err_is_write_q, err_is_write_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  always_comb begin
    err_valid_d    = err_valid_q;
    err_is_write_d = err_is_write_q;
    err_addr_d     = err_addr_q;
    if (err_clear_i) begin
      err_valid_d = 1'b0;
    end else if (!err_valid_q) begin
      if (ar_hs && ar_t == ERR) begin
        err_valid_d    = 1'b1;
        err_is_write_d = 1'b0;
        err_addr_d     = s_axil_araddr_i;
      end else if (aw_hs && aw_t == ERR) begin
        err_valid_d    = 1'b1;
        err_is_write_d = 1'b1;
        err_addr_d     = s_axil_awaddr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_addr_q     <= '0;
    end else begin
      err_valid_q    <= err_valid_d;
      err_is_write_q <= err_is_write_d;
      err_addr_q     <= err_addr_d;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_is_write_o = err_is_write_q;
  assign err_addr_o     = err_addr_q;
`endif

endmodule

// File: tb/tb_loom_axil_demux_ot.sv
// tb_loom_axil_demux_ot: scoreboard bench for loom_axil_demux_ot
// with three in-order slave models of fixed read latency.
module tb_loom_axil_demux_ot;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int LAT = 3;
  localparam logic [N-1:0][AW-1:0] BASE =
    {20'h20000, 20'h10000, 20'h00000};
  localparam logic [N-1:0][AW-1:0] MASK =
    {20'hF0000, 20'hF0000, 20'hF0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   s_araddr = '0, s_awaddr = '0;
  logic            s_arvalid = 0, s_awvalid = 0, s_wvalid = 0;
  logic            s_arready, s_awready, s_wready;
  logic [DW-1:0]   s_wdata = '0;
  logic [DW/8-1:0] s_wstrb = '0;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp, s_bresp;
  logic            s_rvalid, s_bvalid;
  logic            s_rready = 1, s_bready = 1;
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N-1:0]    m_arvalid, m_arready, m_awvalid, m_awready;
  logic [N*DW-1:0] m_wdata, m_rdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N-1:0]    m_wvalid, m_wready, m_rvalid, m_rready;
  logic [N-1:0]    m_bvalid, m_bready;
  logic [N*2-1:0]  m_rresp, m_bresp;

  loom_axil_demux_ot #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_MASTERS(N),
    .MAX_OUTST(4), .BASE_ADDR(BASE), .ADDR_MASK(MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axil_araddr_i(s_araddr), .s_axil_arvalid_i(s_arvalid),
    .s_axil_arready_o(s_arready),
    .s_axil_awaddr_i(s_awaddr), .s_axil_awvalid_i(s_awvalid),
    .s_axil_awready_o(s_awready),
    .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb),
    .s_axil_wvalid_i(s_wvalid), .s_axil_wready_o(s_wready),
    .s_axil_rdata_o(s_rdata), .s_axil_rresp_o(s_rresp),
    .s_axil_rvalid_o(s_rvalid), .s_axil_rready_i(s_rready),
    .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid),
    .s_axil_bready_i(s_bready),
    .m_axil_araddr_o(m_araddr), .m_axil_arvalid_o(m_arvalid),
    .m_axil_arready_i(m_arready),
    .m_axil_awaddr_o(m_awaddr), .m_axil_awvalid_o(m_awvalid),
    .m_axil_awready_i(m_awready),
    .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb),
    .m_axil_wvalid_o(m_wvalid), .m_axil_wready_i(m_wready),
    .m_axil_rdata_i(m_rdata), .m_axil_rresp_i(m_rresp),
    .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(m_rready),
    .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid),
    .m_axil_bready_o(m_bready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rcnt = 0;
  int bcnt = 0;
  int cyc = 0;

  logic [33:0]   rexp[$];
  logic [1:0]    bexp[$];
  logic [AW+1:0] arexp[$];
  logic [AW+1:0] awexp[$];
  logic [DW+1:0] wexp[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h, want nothing", nm, act);
  endtask

  // Slave models: always ready, in-order, read latency LAT,
  // rdata tags slave index and relative address, bresp = index.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_sl
    logic [AW-1:0] ra [8];
    int rt [8];
    int rh, rtail, awn, wn, bn;
    assign m_arready[g] = 1'b1;
    assign m_awready[g] = 1'b1;
    assign m_wready[g]  = 1'b1;
    assign m_rvalid[g] = (rh != rtail) && (cyc >= rt[rh[2:0]] + LAT);
    assign m_rdata[g*DW +: DW] = 32'hD000_0000 |
      (32'(g) << 24) | 32'(ra[rh[2:0]]);
    assign m_rresp[g*2 +: 2] = 2'b00;
    assign m_bvalid[g] = (((awn < wn) ? awn : wn) > bn);
    assign m_bresp[g*2 +: 2] = 2'(g);
    always @(posedge clk) begin
      if (!rst_n) begin
        rh <= 0; rtail <= 0; awn <= 0; wn <= 0; bn <= 0;
      end else begin
        if (m_arvalid[g]) begin
          ra[rtail[2:0]] <= m_araddr[g*AW +: AW];
          rt[rtail[2:0]] <= cyc;
          rtail <= rtail + 1;
        end
        if (m_rvalid[g] && m_rready[g]) rh <= rh + 1;
        if (m_awvalid[g]) awn <= awn + 1;
        if (m_wvalid[g]) wn <= wn + 1;
        if (m_bvalid[g] && m_bready[g]) bn <= bn + 1;
      end
    end
  end

  // Monitor: pops expectations whenever a handshake is presented.
  always @(negedge clk) begin
    if (s_rvalid && s_rready) begin
      if (rexp.size() == 0) unexp("r_beat", 64'({s_rresp, s_rdata}));
      else chk("r_beat", 64'({s_rresp, s_rdata}), 64'(rexp.pop_front()));
      rcnt++;
    end
    if (s_bvalid && s_bready) begin
      if (bexp.size() == 0) unexp("b_resp", 64'(s_bresp));
      else chk("b_resp", 64'(s_bresp), 64'(bexp.pop_front()));
      bcnt++;
    end
    for (int g = 0; g < N; g++) begin
      if (m_arvalid[g]) begin
        if (arexp.size() == 0)
          unexp("m_ar", 64'({2'(g), m_araddr[g*AW +: AW]}));
        else chk("m_ar", 64'({2'(g), m_araddr[g*AW +: AW]}),
                 64'(arexp.pop_front()));
      end
      if (m_awvalid[g]) begin
        if (awexp.size() == 0)
          unexp("m_aw", 64'({2'(g), m_awaddr[g*AW +: AW]}));
        else chk("m_aw", 64'({2'(g), m_awaddr[g*AW +: AW]}),
                 64'(awexp.pop_front()));
      end
      if (m_wvalid[g]) begin
        if (wexp.size() == 0)
          unexp("m_w", 64'({2'(g), m_wdata[g*DW +: DW]}));
        else chk("m_w", 64'({2'(g), m_wdata[g*DW +: DW]}),
                 64'(wexp.pop_front()));
      end
    end
  end

  task automatic rd(input logic [AW-1:0] a, input logic [33:0] er,
                    input int sl, input logic [AW-1:0] rel,
                    output int st);
    rexp.push_back(er);
    if (sl < N) arexp.push_back({2'(sl), rel});
    s_araddr = a;
    s_arvalid = 1'b1;
    st = 0;
    @(negedge clk);
    while (!s_arready && st < 200) begin
      st++;
      @(negedge clk);
    end
    if (!s_arready) unexp("ar_timeout", 64'(st));
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input int lead, input int sl,
                    input logic [AW-1:0] rel, input logic [1:0] eb,
                    output int st, output bit sync);
    bit awd, wd, an, wn;
    bexp.push_back(eb);
    if (sl < N) begin
      awexp.push_back({2'(sl), rel});
      wexp.push_back({2'(sl), d});
    end
    s_wdata = d;
    s_wstrb = '1;
    s_wvalid = 1'b1;
    for (int k = 0; k < lead; k++) begin
      @(negedge clk);
      chk("w_before_aw_wready", 64'(s_wready), 64'(0));
      @(posedge clk);
      #1;
    end
    s_awaddr = a;
    s_awvalid = 1'b1;
    st = 0; sync = 0; awd = 0; wd = 0;
    while (!(awd && wd)) begin
      @(negedge clk);
      an = s_awvalid && s_awready;
      wn = s_wvalid && s_wready;
      if (an && wn) sync = 1;
      if (!an && !awd) st++;
      @(posedge clk);
      #1;
      if (an) begin awd = 1; s_awvalid = 1'b0; end
      if (wn) begin wd = 1; s_wvalid = 1'b0; end
      if (st >= 200) begin
        unexp("wr_timeout", 64'(st));
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((rexp.size() + bexp.size()) != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    chk(nm, 64'(rexp.size() + bexp.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int st, st5, r0, b0;
  bit sync;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({s_arready, s_awready, s_wready, s_rvalid,
        s_bvalid, s_rdata, s_rresp, s_bresp, m_arvalid, m_awvalid,
        m_wvalid, m_rready, m_bready}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: back-to-back reads to slave 1
    rd(20'h10000, {2'b00, 32'hD100_0000}, 1, 20'h00000, st);
    chk("t1_stall0", 64'(st), 64'(0));
    rd(20'h10004, {2'b00, 32'hD100_0004}, 1, 20'h00004, st);
    chk("t1_stall1", 64'(st), 64'(0));
    rd(20'h10008, {2'b00, 32'hD100_0008}, 1, 20'h00008, st);
    chk("t1_stall2", 64'(st), 64'(0));
    rd(20'h1000C, {2'b00, 32'hD100_000C}, 1, 20'h0000C, st);
    chk("t1_stall3", 64'(st), 64'(0));
    drain("t1_drain");

    // 2: target switch waits for the pending read
    rd(20'h00020, {2'b00, 32'hD000_0020}, 0, 20'h00020, st);
    chk("t2_first_nostall", 64'(st), 64'(0));
    r0 = rcnt;
    rd(20'h20044, {2'b00, 32'hD200_0044}, 2, 20'h00044, st);
    chk("t2_switch_stalled", 64'(st > 0), 64'(1));
    chk("t2_r_before_ar", 64'(rcnt), 64'(r0 + 1));
    drain("t2_drain");

    // 3: unmapped read answered by the error slave
    rd(20'h30000, {2'b11, 32'h0}, N, 20'h0, st);
    chk("t3_arready", 64'(st), 64'(0));
    chk("t3_rvalid_next", 64'(s_rvalid), 64'(1));
    drain("t3_drain");

    // 4: AW+W together, then W ahead of AW, then unmapped write
    wr(20'h20010, 32'hCAFE_0001, 0, 2, 20'h00010, 2'b10, st, sync);
    chk("t4_aw_nostall", 64'(st), 64'(0));
    chk("t4_same_cycle", 64'(sync), 64'(1));
    wr(20'h20014, 32'hCAFE_0002, 2, 2, 20'h00014, 2'b10, st, sync);
    chk("t4_w_with_aw", 64'(sync), 64'(1));
    drain("t4_drain");
    wr(20'h3FFF0, 32'h0000_0BAD, 0, N, 20'h0, 2'b11, st, sync);
    chk("t4_err_nostall", 64'(st), 64'(0));
    drain("t4_err_drain");

    // 5: fill to MAX_OUTST writes with bready low
    s_bready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr(20'h10100 + 20'(4 * k), 32'h5500_0000 + 32'(k), 0, 1,
         20'h00100 + 20'(4 * k), 2'b01, st, sync);
      chk("t5_fill_nostall", 64'(st), 64'(0));
    end
    b0 = bcnt;
    fork
      wr(20'h10110, 32'h5500_0004, 0, 1, 20'h00110, 2'b01, st5, sync);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t5_full_awready", 64'(s_awready), 64'(0));
        chk("t5_full_no_b", 64'(bcnt), 64'(b0));
        @(posedge clk);
        #1;
        s_bready = 1'b1;
      end
    join
    chk("t5_fifth_stalled", 64'(st5 >= 5), 64'(1));
    chk("t5_b_before_aw", 64'(bcnt > b0), 64'(1));
    drain("t5_drain");
    chk("t5_all_b", 64'(bcnt - b0), 64'(5));

    // 6: reset with two reads outstanding
    rd(20'h00000, {2'b00, 32'hD000_0000}, 0, 20'h00000, st);
    rd(20'h00004, {2'b00, 32'hD000_0004}, 0, 20'h00004, st);
    rst_n = 1'b0;
    s_araddr = 20'h00000;
    s_arvalid = 1'b1;
    s_awvalid = 1'b1;
    s_wvalid = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_outs", 64'({s_arready, s_awready, s_wready, s_rvalid,
        s_bvalid, s_rdata, s_rresp, m_arvalid, m_awvalid, m_wvalid,
        m_rready, m_bready}), 64'(0));
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    rexp.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(20'h00008, {2'b00, 32'hD000_0008}, 0, 20'h00008, st);
    chk("t6_fresh_nostall", 64'(st), 64'(0));
    drain("t6_drain");

    chk("end_queues", 64'(arexp.size() + awexp.size() + wexp.size()),
        64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
